// File: rtl/sprite_ram_loader.sv
// Byte-stream loader for sprite RAM: packs BPW bytes (first byte most significant)
// into WIDTH-bit words and writes them sequentially from a latched base address.
module sprite_ram_loader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ADDRW-1:0] base_addr,
    input  logic [ADDRW:0]   word_count,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             wr_en,
    output logic [ADDRW-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done
);

    localparam int BPW = WIDTH / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [ADDRW-1:0] r_addr;
    logic [ADDRW:0]   r_words;
    logic [BCW-1:0]   r_byte_cnt;
    logic [WIDTH-1:0] r_shift;

    logic             w_accept;
    logic             w_word_end;
    logic             w_last_word;
    logic [WIDTH-1:0] w_packed;

    // abort wins over a byte presented in the same cycle
    assign w_accept    = (r_state == S_LOAD) && in_valid && !abort;
    assign w_word_end  = w_accept && (r_byte_cnt == BCW'(BPW - 1));
    assign w_last_word = w_word_end && (r_words == (ADDRW + 1)'(1));
    assign w_packed    = (r_shift << 8) | WIDTH'(in_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (word_count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last_word) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_words    <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            if (r_state == S_IDLE && start) begin
                r_addr     <= base_addr;
                r_words    <= word_count;
                r_byte_cnt <= '0;
                r_shift    <= '0;
            end else if (r_state == S_LOAD && abort) begin
                r_byte_cnt <= '0;
                r_shift    <= '0;
            end else if (w_accept) begin
                if (w_word_end) begin
                    wr_en      <= 1'b1;
                    wr_addr    <= r_addr;
                    wr_data    <= w_packed;
                    r_addr     <= (r_addr == ADDRW'(DEPTH - 1)) ? '0 : r_addr + ADDRW'(1);
                    r_words    <= r_words - (ADDRW + 1)'(1);
                    r_byte_cnt <= '0;
                    r_shift    <= '0;
                end else begin
                    r_shift    <= w_packed;
                    r_byte_cnt <= r_byte_cnt + BCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed bench for sprite_ram_loader: an 8-bit and a 16-bit instance share clock and
// reset; expected RAM writes are queued when stimulus is driven and checked as they appear.
module tb_sprite_ram_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel16;
    logic        start, abort, in_valid;
    logic [7:0]  base_addr, in_data;
    logic [8:0]  word_count;

    logic        in_ready8, wr_en8, busy8, done8;
    logic [7:0]  wr_addr8, wr_data8;
    logic        in_ready16, wr_en16, busy16, done16;
    logic [7:0]  wr_addr16;
    logic [15:0] wr_data16;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t q8[$];
    wr_t q16[$];
    wr_t e8, e16;
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  done8_cnt = 0;
    int  done16_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_ram_loader #(.WIDTH(8), .DEPTH(DEPTH)) u_dut8 (
        .clk(clk), .reset(reset), .start(start & ~sel16), .base_addr(base_addr),
        .word_count(word_count), .abort(abort & ~sel16), .in_valid(in_valid & ~sel16),
        .in_data(in_data), .in_ready(in_ready8), .wr_en(wr_en8), .wr_addr(wr_addr8),
        .wr_data(wr_data8), .busy(busy8), .done(done8)
    );

    sprite_ram_loader #(.WIDTH(16), .DEPTH(DEPTH)) u_dut16 (
        .clk(clk), .reset(reset), .start(start & sel16), .base_addr(base_addr),
        .word_count(word_count), .abort(abort & sel16), .in_valid(in_valid & sel16),
        .in_data(in_data), .in_ready(in_ready16), .wr_en(wr_en16), .wr_addr(wr_addr16),
        .wr_data(wr_data16), .busy(busy16), .done(done16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
    endtask

    task automatic gap();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic push8(input logic [7:0] a, input logic [15:0] d);
        q8.push_back('{addr: a, data: d, cyc: cyc + 1});
    endtask

    task automatic push16(input logic [7:0] a, input logic [15:0] d);
        q16.push_back('{addr: a, data: d, cyc: cyc + 1});
    endtask

    task automatic begin_load(input logic [7:0] base, input logic [8:0] cnt);
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Scoreboard: every write strobe must match the oldest queued expectation and its cycle.
    always @(negedge clk) begin
        if (done8) done8_cnt++;
        if (done16) done16_cnt++;
        if (wr_en8) begin
            check("wr8_expected", 32'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                check("wr8_addr", 32'(wr_addr8), 32'(e8.addr));
                check("wr8_data", 32'(wr_data8), 32'(e8.data));
                check("wr8_cycle", 32'(cyc), 32'(e8.cyc));
            end
        end
        if (wr_en16) begin
            check("wr16_expected", 32'(q16.size() != 0), 1);
            if (q16.size() != 0) begin
                e16 = q16.pop_front();
                check("wr16_addr", 32'(wr_addr16), 32'(e16.addr));
                check("wr16_data", 32'(wr_data16), 32'(e16.data));
                check("wr16_cycle", 32'(cyc), 32'(e16.cyc));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        sel16      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        base_addr  = 8'h00;
        word_count = 9'd0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready8), 0);
        check("rst_wr_en", 32'(wr_en8), 0);
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_wr_addr", 32'(wr_addr8), 0);
        check("rst_wr_data", 32'(wr_data8), 0);
        reset = 1'b0;
        tick();

        // 1: WIDTH=8, three back-to-back bytes
        base_addr  = 8'h10;
        word_count = 9'd3;
        start      = 1'b1;
        check("t1_idle_ready", 32'(in_ready8), 0);
        tick();
        start = 1'b0;
        check("t1_busy", 32'(busy8), 1);
        check("t1_ready", 32'(in_ready8), 1);
        push8(8'h10, 16'h00A1); send(8'hA1);
        push8(8'h11, 16'h00B2); send(8'hB2);
        push8(8'h12, 16'h00C3); send(8'hC3);
        check("t1_done", 32'(done8), 1);
        check("t1_done_with_wr", 32'(wr_en8), 1);
        check("t1_ready_drop", 32'(in_ready8), 0);
        check("t1_busy_done", 32'(busy8), 0);
        gap();
        check("t1_done_pulse", 32'(done8), 0);
        check("t1_idle_busy", 32'(busy8), 0);

        // 3: address wrap from 0xFE
        begin_load(8'hFE, 9'd4);
        push8(8'hFE, 16'h0001); send(8'h01);
        push8(8'hFF, 16'h0002); send(8'h02);
        push8(8'h00, 16'h0003); send(8'h03);
        push8(8'h01, 16'h0004); send(8'h04);
        check("t3_done", 32'(done8), 1);
        gap();
        check("t3_busy_after", 32'(busy8), 0);
        check("t3_wr_en_clear", 32'(wr_en8), 0);
        check("t3_addr_hold", 32'(wr_addr8), 32'h01);

        // 4: zero-length load
        base_addr  = 8'h33;
        word_count = 9'd0;
        in_valid   = 1'b1;
        in_data    = 8'hEE;
        start      = 1'b1;
        check("t4_ready_idle", 32'(in_ready8), 0);
        tick();
        start = 1'b0;
        check("t4_done", 32'(done8), 1);
        check("t4_ready_done", 32'(in_ready8), 0);
        check("t4_busy", 32'(busy8), 0);
        tick();
        check("t4_done_pulse", 32'(done8), 0);
        check("t4_ready_after", 32'(in_ready8), 0);
        in_valid = 1'b0;

        // 2: WIDTH=16 with valid gaps
        sel16 = 1'b1;
        begin_load(8'h40, 9'd2);
        send(8'h12);
        gap();
        check("t2_no_wr_gap", 32'(wr_en16), 0);
        push16(8'h40, 16'h1234); send(8'h34);
        gap();
        gap();
        check("t2_wr_pulse", 32'(wr_en16), 0);
        check("t2_data_hold", 32'(wr_data16), 32'h1234);
        send(8'h56);
        gap();
        push16(8'h41, 16'h5678); send(8'h78);
        check("t2_done", 32'(done16), 1);
        check("t2_done_with_wr", 32'(wr_en16), 1);
        gap();
        check("t2_done_pulse", 32'(done16), 0);

        // 5: abort mid-word, then a fresh load
        begin_load(8'h80, 9'd3);
        send(8'hAA);
        push16(8'h80, 16'hAABB); send(8'hBB);
        send(8'hCC);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hDD;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("t5_busy", 32'(busy16), 0);
        check("t5_no_done", 32'(done16), 0);
        check("t5_ready", 32'(in_ready16), 0);
        tick();
        tick();
        begin_load(8'h90, 9'd1);
        send(8'h11);
        push16(8'h90, 16'h1122); send(8'h22);
        check("t5_reload_done", 32'(done16), 1);
        gap();

        // 6: start ignored while busy, then asynchronous reset mid-word
        begin_load(8'h20, 9'd2);
        send(8'h55);
        start      = 1'b1;
        base_addr  = 8'h70;
        word_count = 9'd5;
        push16(8'h20, 16'h5566); send(8'h66);
        start = 1'b0;
        send(8'h77);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t6_rst_ready", 32'(in_ready16), 0);
        check("t6_rst_wr_en", 32'(wr_en16), 0);
        check("t6_rst_busy", 32'(busy16), 0);
        check("t6_rst_done", 32'(done16), 0);
        check("t6_rst_addr", 32'(wr_addr16), 0);
        check("t6_rst_data", 32'(wr_data16), 0);
        tick();
        reset = 1'b0;
        send(8'h99);
        send(8'h98);
        send(8'h97);
        in_valid = 1'b0;
        check("t6_idle_busy", 32'(busy16), 0);
        check("t6_idle_ready", 32'(in_ready16), 0);
        tick();
        #1;

        check("end_q8_empty", 32'(q8.size()), 0);
        check("end_q16_empty", 32'(q16.size()), 0);
        check("end_done8_count", 32'(done8_cnt), 3);
        check("end_done16_count", 32'(done16_cnt), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
